// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcodes, datapath select values
// and the Moore output table used by the controller's registered output stage.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'h0,
    S_DECODE = 4'h1,
    S_EXECR  = 4'h2,
    S_EXECI  = 4'h3,
    S_MEMADR = 4'h4,
    S_MEMRD  = 4'h5,
    S_MEMWB  = 4'h6,
    S_MEMWR  = 4'h7,
    S_ALUWB  = 4'h8,
    S_BRANCH = 4'h9,
    S_HALT   = 4'hA
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LDR  = 4'h5;
  localparam logic [3:0] OP_STR  = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_B    = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REGB = 2'b00,
    SRCB_ONE  = 2'b01,
    SRCB_IMM  = 2'b10
  } srcb_t;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'b00,
    RES_MEMDATA = 2'b01,
    RES_ALU     = 2'b10
  } res_t;

  typedef struct packed {
    logic    pc_write;
    logic    ir_write;
    logic    reg_write;
    logic    mem_write;
    logic    adr_src;
    logic    alu_src_a;
    srcb_t   alu_src_b;
    alu_op_t alu_op;
    res_t    result_src;
  } ctrl_t;

  // Moore outputs of a state; alu_fn is Opcode[1:0], only meaningful in EXECR.
  function automatic ctrl_t state_ctrl(state_t s, logic [1:0] alu_fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_write   = 1'b1;
        c.alu_src_b  = SRCB_ONE;
        c.result_src = RES_ALU;
      end
      S_DECODE: c.alu_src_b = SRCB_IMM;
      S_EXECR: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = alu_op_t'({1'b0, alu_fn});
      end
      S_EXECI, S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = RES_MEMDATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle; master is the control unit, slave the datapath.
// MCCTRL_MEM_WAIT_EN adds the MemReady handshake from memory.
interface multicycle_control_if #(parameter int CW = 16);
  logic [3:0]    Opcode;
  logic          Zero;
`ifdef MCCTRL_MEM_WAIT_EN
  logic          MemReady;
`endif
  logic          PCWrite;
  logic          IRWrite;
  logic          RegWrite;
  logic          MemWrite;
  logic          AdrSrc;
  logic          ALUSrcA;
  logic [1:0]    ALUSrcB;
  logic [2:0]    ALUOp;
  logic [1:0]    ResultSrc;
  logic [3:0]    State;
  logic          Illegal;
  logic [CW-1:0] RetireCount;

`ifdef MCCTRL_MEM_WAIT_EN
  modport master (input Opcode, Zero, MemReady,
                  output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
                         ALUOp, ResultSrc, State, Illegal, RetireCount);
  modport slave  (output Opcode, Zero, MemReady,
                  input PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
                        ALUOp, ResultSrc, State, Illegal, RetireCount);
`else
  modport master (input Opcode, Zero,
                  output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
                         ALUOp, ResultSrc, State, Illegal, RetireCount);
  modport slave  (output Opcode, Zero,
                  input PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
                        ALUOp, ResultSrc, State, Illegal, RetireCount);
`endif
endinterface

// File: rtl/mc_instr_decode.sv
// Combinational opcode classifier; zero latency, no flow control.
module mc_instr_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic       o_is_rtype,
  output logic       o_is_addi,
  output logic       o_is_ldr,
  output logic       o_is_str,
  output logic       o_is_beq,
  output logic       o_is_b,
  output logic       o_is_halt,
  output logic       o_is_illegal
);

  always_comb begin
    o_is_rtype   = 1'b0;
    o_is_addi    = 1'b0;
    o_is_ldr     = 1'b0;
    o_is_str     = 1'b0;
    o_is_beq     = 1'b0;
    o_is_b       = 1'b0;
    o_is_halt    = 1'b0;
    o_is_illegal = 1'b0;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: o_is_rtype = 1'b1;
      OP_ADDI: o_is_addi = 1'b1;
      OP_LDR:  o_is_ldr  = 1'b1;
      OP_STR:  o_is_str  = 1'b1;
      OP_BEQ:  o_is_beq  = 1'b1;
      OP_B:    o_is_b    = 1'b1;
      OP_HALT: o_is_halt = 1'b1;
      default: o_is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM with registered Moore outputs, Mealy branch PCWrite and retire counter.
// MCCTRL_MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall on MemReady low; otherwise memory is single-cycle.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  multicycle_control_if.master bus
);

  state_t        r_state;
  state_t        w_next;
  ctrl_t         r_ctrl;
  ctrl_t         w_ctrl;
  logic          r_illegal;
  logic [CW-1:0] r_retire;
  logic          w_mem_rdy;
  logic          w_retire;
  logic          w_br_take;
  logic          w_fetch_gate;
  logic          w_is_rtype, w_is_addi, w_is_ldr, w_is_str;
  logic          w_is_beq, w_is_b, w_is_halt, w_is_illegal;

`ifdef MCCTRL_MEM_WAIT_EN
  assign w_mem_rdy = bus.MemReady;
`else
  assign w_mem_rdy = 1'b1;
`endif

  mc_instr_decode u_dec (
    .i_opcode     (bus.Opcode),
    .o_is_rtype   (w_is_rtype),
    .o_is_addi    (w_is_addi),
    .o_is_ldr     (w_is_ldr),
    .o_is_str     (w_is_str),
    .o_is_beq     (w_is_beq),
    .o_is_b       (w_is_b),
    .o_is_halt    (w_is_halt),
    .o_is_illegal (w_is_illegal)
  );

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_is_rtype)               w_next = S_EXECR;
        else if (w_is_addi)           w_next = S_EXECI;
        else if (w_is_ldr || w_is_str) w_next = S_MEMADR;
        else if (w_is_beq || w_is_b)  w_next = S_BRANCH;
        else if (w_is_halt)           w_next = S_HALT;
        else                          w_next = S_FETCH;
      end
      S_EXECR, S_EXECI: w_next = S_ALUWB;
      S_MEMADR: w_next = w_is_ldr ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = w_mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = w_mem_rdy ? S_FETCH : S_MEMWR;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  // FETCH self-loops while waiting on memory, so it is excluded from the retire sources.
  assign w_retire = (w_next == S_FETCH) &&
                    (r_state inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_DECODE});

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= S_FETCH;
      r_ctrl    <= state_ctrl(S_FETCH, 2'b00);
      r_illegal <= 1'b0;
      r_retire  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= state_ctrl(w_next, bus.Opcode[1:0]);
      if (r_state == S_DECODE && w_is_illegal)
        r_illegal <= 1'b1;
      if (w_retire)
        r_retire <= r_retire + CW'(1);
    end
  end

  assign w_br_take    = (r_state == S_BRANCH) && (w_is_b || (w_is_beq && bus.Zero));
  assign w_fetch_gate = (r_state != S_FETCH) || w_mem_rdy;

  always_comb begin
    w_ctrl          = r_ctrl;
    w_ctrl.pc_write = (r_ctrl.pc_write && w_fetch_gate) || w_br_take;
    w_ctrl.ir_write = r_ctrl.ir_write && w_fetch_gate;
    if (Reset) begin
      w_ctrl           = state_ctrl(S_FETCH, 2'b00);
      w_ctrl.pc_write  = 1'b0;
      w_ctrl.ir_write  = 1'b0;
      w_ctrl.reg_write = 1'b0;
      w_ctrl.mem_write = 1'b0;
    end
  end

  assign bus.PCWrite     = w_ctrl.pc_write;
  assign bus.IRWrite     = w_ctrl.ir_write;
  assign bus.RegWrite    = w_ctrl.reg_write;
  assign bus.MemWrite    = w_ctrl.mem_write;
  assign bus.AdrSrc      = w_ctrl.adr_src;
  assign bus.ALUSrcA     = w_ctrl.alu_src_a;
  assign bus.ALUSrcB     = w_ctrl.alu_src_b;
  assign bus.ALUOp       = w_ctrl.alu_op;
  assign bus.ResultSrc   = w_ctrl.result_src;
  assign bus.State       = r_state;
  assign bus.Illegal     = r_illegal;
  assign bus.RetireCount = r_retire;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through its state sequence.
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   exp_ret = 0;

  multicycle_control_if #(.CW(16)) bus();
  multicycle_control #(.CW(16)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge Clock);
    #2;
  endtask

  // en = {PCWrite, IRWrite, RegWrite, MemWrite}
  task automatic at(input string tag, input logic [3:0] st, input logic [3:0] en);
    #1;
    check({tag, "/state"}, 32'(bus.State), 32'(st));
    check({tag, "/en"}, 32'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}), 32'(en));
  endtask

  task automatic retired(input string tag);
    exp_ret = (exp_ret + 1) % 65536;
    #1;
    check({tag, "/retire"}, 32'(bus.RetireCount), 32'(exp_ret));
  endtask

  task automatic fetch_decode(input string tag, input logic [3:0] opc);
    bus.Opcode = opc;
    at({tag, "/F"}, 4'h0, 4'b1100);
    check({tag, "/F_srcb"}, 32'(bus.ALUSrcB), 32'd1);
    adv();
    at({tag, "/D"}, 4'h1, 4'b0000);
    check({tag, "/D_srcb"}, 32'(bus.ALUSrcB), 32'd2);
    adv();
  endtask

  task automatic branch(input string tag, input logic [3:0] opc, input logic z, input logic pcw);
    fetch_decode(tag, opc);
    bus.Zero = z;
    at({tag, "/BR"}, 4'h9, {pcw, 3'b000});
    check({tag, "/BR_op"}, 32'(bus.ALUOp), 32'd1);
    adv();
    bus.Zero = 1'b0;
    retired(tag);
  endtask

  initial begin
    bus.Opcode = OP_ADD;
    bus.Zero   = 1'b0;
`ifdef MCCTRL_MEM_WAIT_EN
    bus.MemReady = 1'b1;
`endif
    Reset = 1'b1;
    adv();
    adv();
    at("rst", 4'h0, 4'b0000);
    check("rst/srcb", 32'(bus.ALUSrcB), 32'd1);
    check("rst/ressrc", 32'(bus.ResultSrc), 32'd2);
    check("rst/adrsrc", 32'(bus.AdrSrc), 32'd0);
    check("rst/retire", 32'(bus.RetireCount), 32'd0);
    check("rst/illegal", 32'(bus.Illegal), 32'd0);
    Reset = 1'b0;

    fetch_decode("add", OP_ADD);
    at("add/X", 4'h2, 4'b0000);
    check("add/X_srca", 32'(bus.ALUSrcA), 32'd1);
    check("add/X_srcb", 32'(bus.ALUSrcB), 32'd0);
    check("add/X_op", 32'(bus.ALUOp), 32'd0);
    adv();
    at("add/WB", 4'h8, 4'b0010);
    check("add/WB_res", 32'(bus.ResultSrc), 32'd0);
    adv();
    retired("add");

    fetch_decode("or", OP_OR);
    at("or/X", 4'h2, 4'b0000);
    check("or/X_op", 32'(bus.ALUOp), 32'd3);
    adv();
    at("or/WB", 4'h8, 4'b0010);
    adv();
    retired("or");

    branch("beq1", OP_BEQ, 1'b1, 1'b1);
    branch("beq0", OP_BEQ, 1'b0, 1'b0);
    branch("b0", OP_B, 1'b0, 1'b1);

    fetch_decode("ldr", OP_LDR);
    at("ldr/MA", 4'h4, 4'b0000);
    check("ldr/MA_srcb", 32'(bus.ALUSrcB), 32'd2);
    adv();
    at("ldr/RD", 4'h5, 4'b0000);
    check("ldr/RD_adr", 32'(bus.AdrSrc), 32'd1);
    adv();
    at("ldr/WB", 4'h6, 4'b0010);
    check("ldr/WB_res", 32'(bus.ResultSrc), 32'd1);
    adv();
    retired("ldr");

    fetch_decode("str", OP_STR);
    at("str/MA", 4'h4, 4'b0000);
    adv();
    at("str/WR", 4'h7, 4'b0001);
    check("str/WR_adr", 32'(bus.AdrSrc), 32'd1);
    adv();
    retired("str");

    fetch_decode("ill", 4'hC);
    retired("ill");
    check("ill/flag", 32'(bus.Illegal), 32'd1);

`ifdef MCCTRL_MEM_WAIT_EN
    fetch_decode("wstr", OP_STR);
    at("wstr/MA", 4'h4, 4'b0000);
    adv();
    bus.MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at("wstr/wait", 4'h7, 4'b0001);
      adv();
    end
    bus.MemReady = 1'b1;
    at("wstr/WR", 4'h7, 4'b0001);
    adv();
    retired("wstr");

    fetch_decode("wldr", OP_LDR);
    at("wldr/MA", 4'h4, 4'b0000);
    adv();
    bus.MemReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      at("wldr/wait", 4'h5, 4'b0000);
      adv();
    end
    bus.MemReady = 1'b1;
    at("wldr/RD", 4'h5, 4'b0000);
    adv();
    at("wldr/WB", 4'h6, 4'b0010);
    adv();
    retired("wldr");

    bus.MemReady = 1'b0;
    at("wfetch", 4'h0, 4'b0000);
    adv();
    bus.MemReady = 1'b1;
`endif

    fetch_decode("rstm", OP_LDR);
    at("rstm/MA", 4'h4, 4'b0000);
    adv();
    at("rstm/RD", 4'h5, 4'b0000);
    Reset = 1'b1;
    #1;
    check("rstm/RD_en", 32'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}), 32'd0);
    adv();
    at("rstm/after", 4'h0, 4'b0000);
    exp_ret = 0;
    check("rstm/retire", 32'(bus.RetireCount), 32'd0);
    check("rstm/illegal", 32'(bus.Illegal), 32'd0);
    Reset = 1'b0;

    fetch_decode("halt", OP_HALT);
    for (int i = 0; i < 20; i++) begin
      at("halt", 4'hA, 4'b0000);
      adv();
    end
    check("halt/retire", 32'(bus.RetireCount), 32'(exp_ret));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore/Mealy finite-state control unit for the multicycle processor. Each cycle it decodes the latched opcode and the ALU Zero flag, then drives the per-cycle write enables and datapath mux selects. The write enables feed the PC, IR, register-file and memory enable pins; the mux selects feed the datapath multiplexers. The block also keeps a retired-instruction counter for debug and performance.

## Interface
- CW, 16, width of RetireCount
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Opcode  in  4  instruction opcode from IR[15:12]
- Zero  in  1  ALU zero flag, combinational from current ALU result
- MemReady  in  1  memory access complete (present only with MCCTRL_MEM_WAIT_EN)
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  register/memory write enables
- AdrSrc  out  1  memory address: 0 PC, 1 ALUOut
- ALUSrcA  out  1  0 PC, 1 regA
- ALUSrcB  out  2  00 regB, 01 constant 1, 10 sign-extended imm
- ALUOp  out  3  000 ADD, 001 SUB, 010 AND, 011 OR
- ResultSrc  out  2  00 ALUOut, 01 memory data reg, 10 ALU direct
- State  out  4  current state code (debug)
- Illegal  out  1  sticky, set on an undefined opcode
- RetireCount  out  CW  instructions completed, wraps

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LDR, 6 STR, 7 BEQ, 8 B, F HALT. All others are undefined: they set Illegal and behave as NOP.
- State codes:
  - 0 FETCH, 1 DECODE, 2 EXECR, 3 EXECI, 4 MEMADR, 5 MEMRD, 6 MEMWB, 7 MEMWR, 8 ALUWB, 9 BRANCH, A HALT.
  - Codes B–F are unreachable and recover to FETCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, ResultSrc=10, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=ADD (precomputes the branch target into ALUOut). Next state by opcode:
  - R-type (0–3) → EXECR
  - ADDI → EXECI
  - LDR, STR → MEMADR
  - BEQ, B → BRANCH
  - HALT → HALT
  - undefined → FETCH
- EXECR: ALUSrcA=1, ALUSrcB=00, ALUOp=Opcode[1:0] zero-extended. Next state ALUWB.
- EXECI and MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. EXECI → ALUWB. MEMADR → MEMRD (LDR) or MEMWR (STR).
- MEMRD: AdrSrc=1. Next state MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
- MEMWR: AdrSrc=1, MemWrite=1. Next state FETCH.
- ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, ResultSrc=00. PCWrite = (Opcode==B) | (Opcode==BEQ & Zero); this is the only Mealy output. Next state FETCH.
- HALT: all enables 0. Stays in HALT until Reset.
- Any output not listed for a state is 0.
- RetireCount increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH or DECODE (undefined opcode). It wraps from 2^CW−1 to 0.

## Timing
- Reset: state FETCH, RetireCount 0, Illegal 0.
  - While Reset is high, all four write enables are forced to 0.
  - Mux selects follow the FETCH values.
- Reset mid-instruction aborts the instruction; FETCH begins on the cycle after Reset deasserts.
- Cycles per instruction without wait states: R-type/ADDI 4, LDR 5, STR 4, BEQ/B 3, undefined 2.
- Branch: Zero is sampled combinationally in the BRANCH cycle; PC updates on that cycle's edge.
- Illegal sets on the edge leaving DECODE and clears only on Reset.

## Configuration
- MCCTRL_MEM_WAIT_EN defined:
  - The MemReady port exists.
  - FETCH, MEMRD and MEMWR hold their state while MemReady=0.
  - In FETCH, IRWrite and PCWrite are gated by MemReady.
  - In MEMWR, MemWrite stays high for the whole wait.
  - Each cycle with MemReady low adds one cycle of latency.
- MCCTRL_MEM_WAIT_EN undefined: no MemReady port; every memory access is single-cycle.

## Structure
- Package mc_ctrl_pkg holds:
  - state codes
  - opcode constants
  - ALUOp, ALUSrcB and ResultSrc encodings
- Sub-module mc_instr_decode: combinational Opcode → {is_rtype, is_addi, is_ldr, is_str, is_beq, is_b, is_halt, is_illegal}.

## Test plan
- ADD (Opcode 0) after reset → states 0,1,2,8,0; RegWrite=1 only in ALUWB; RetireCount 0→1.
- BEQ with Zero=1 → PCWrite=1 in BRANCH. BEQ with Zero=0 → PCWrite=0. B with Zero=0 → PCWrite=1.
- LDR then STR → LDR takes 5 cycles with ResultSrc=01 in MEMWB; STR asserts MemWrite for exactly 1 cycle with AdrSrc=1.
- Opcode 0xC → Illegal=1, back in FETCH after 2 cycles, RetireCount +1. HALT → State stays 0xA for 20 cycles with all enables 0.
- Reset asserted in MEMRD → next state FETCH, RetireCount 0, no RegWrite pulse.
- MCCTRL_MEM_WAIT_EN defined, MemReady low 3 cycles in MEMWR → MemWrite high 4 cycles, LDR latency 5+N.
